clk_div_multi: RTL
==================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider, successor to the fixed-N single-output divider.
- NCH independent channels, each with a run-time divisor, per-channel enable and a registered divided level plus a one-cycle tick.
- Divisor changes are applied glitch-free at period boundaries, and a global sync input realigns all channels.
- Fully single-clock; outputs feed LEDs, the heater PWM timebase and display-scan logic as clock enables, not as clocks.

Parameters:
- NCH, 4, number of channels (1..16)
- WIDTH, 8, divisor and counter width; maximum divisor 2**WIDTH-1
- DEF_DIV, 5, active divisor of every channel after reset (2..2**WIDTH-1)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- en  in  NCH  per-channel run enable
- sync  in  1  one-cycle pulse; restarts every enabled channel at count 0
- div_wr  in  NCH  per-channel write strobe for div_in
- div_in  in  WIDTH  divisor value, shared write bus
- clk_out  out  NCH  divided level per channel
- tick  out  NCH  one-cycle pulse per channel, once per divided period
- pend  out  NCH  channel has a written divisor not yet applied

Behaviour:
- Per-channel state:
  - cnt[WIDTH]: counter.
  - act[WIDTH]: active divisor.
  - nxt[WIDTH]: pending divisor.
  - pend flag.
- All outputs are registered. Every decision is made on the rising clk edge.
- Reset (rst=1) has priority over everything:
  - cnt=0, act=DEF_DIV, nxt=DEF_DIV.
  - pend=0, clk_out=0, tick=0 for all channels.
- Effective divisor E = act, except that act=0 or act=1 is treated as 1.
- Running channel (en=1, E>=2):
  - cnt counts 0..E-1 and wraps to 0.
  - clk_out is 0 while cnt < E>>1 and 1 otherwise. This gives 50% duty for even E; for odd E the high phase is one clk longer.
  - tick=1 for exactly one cycle, in the cycle after cnt==E-1.
  - After en rises, the first tick appears E cycles later.
- Running channel with E=1: tick=1 every cycle and clk_out=1 constant.
- Disabled channel (en=0):
  - cnt held at 0, clk_out=0, tick=0.
  - A pending divisor is applied immediately: act<=nxt, pend<=0.
  - Re-enabling starts at cnt=0.
- Divisor write (div_wr[i]=1): nxt[i]<=div_in and pend[i]<=1 on the next edge.
  - A second write before application overwrites nxt. Only the last value is used.
- Application on a running channel: at the edge where cnt==E-1 and pend=1, act<=nxt, pend<=0, cnt<=0.
  - The new divisor governs the very next period.
  - No truncated or stretched period may appear on clk_out.
- Write coinciding with the wrap edge: the write is captured into nxt. The old pend/nxt is applied on that edge. The new write stays pending for the following boundary, so pend remains 1.
- sync=1 (and rst=0):
  - Every enabled channel: cnt<=0, pending divisor applied, tick=0, clk_out=0 in the following cycle.
  - sync has priority over wrap and over normal application.
  - Disabled channels are unaffected.
- Same-edge priority: rst > sync > en=0 > div_wr capture > wrap/apply > count.
- Counter width: cnt never exceeds act-1. The comparison cnt==E-1 is done at WIDTH bits.
- Reset mid-period: the channel restarts cleanly from the reset state. No partial pulse appears on tick.

Test Plan:
- Reset, DEF_DIV=5, en=4'b0001 -> ch0 clk_out repeats 0,0,1,1,1; tick every 5 cycles, first tick 5 cycles after en; other channels stay 0.
- Write 6 to ch0 at cnt=1 -> pend=1 until the wrap; the current 5-cycle period completes intact; next periods are 3 low/3 high; pend clears on the wrap edge.
- Writes of 7 then 9 to ch1 within one period -> only 9 is applied at the boundary; period is 4 low/5 high.
- Write 4 to ch2 on the exact edge where cnt==E-1 -> old divisor is used for one more period, then 4; pend is high across the boundary.
- ch0 divisor 5 and ch1 divisor 8 both running, pulse sync -> both cnt=0 on the next cycle; ticks coincide at cycle 40 after sync.
- Write div_in=0 and div_in=1 -> tick high every cycle, clk_out=1; rst mid-period -> all outputs 0 next cycle, act=5.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider producing registered divided levels and
// one-cycle ticks. Divisor updates take effect only at period boundaries, so clk_out never glitches.
module clk_div_multi #(
  parameter int NCH     = 4,
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic [NCH-1:0]   div_wr,
  input  logic [WIDTH-1:0] div_in,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [NCH-1:0][WIDTH-1:0] cnt_q, act_q, nxt_q;
  logic [NCH-1:0][WIDTH-1:0] cnt_d, act_d, nxt_d;
  logic [NCH-1:0][WIDTH-1:0] eff_q, eff_d;
  logic [NCH-1:0]            wrap, pend_d, tick_d, clk_out_d;

  // A divisor of 0 or 1 behaves as 1. A pending divisor is applied on any
  // restart point (disable, sync or wrap). A new write then re-arms pend.
  always_comb begin
    cnt_d     = cnt_q;
    act_d     = act_q;
    nxt_d     = nxt_q;
    pend_d    = pend;
    tick_d    = '0;
    clk_out_d = '0;
    eff_q     = '0;
    eff_d     = '0;
    wrap      = '0;
    for (int i = 0; i < NCH; i++) begin
      eff_q[i] = (act_q[i] <= ONE) ? ONE : act_q[i];
      wrap[i]  = (cnt_q[i] == eff_q[i] - ONE);
      if (!en[i] || sync || wrap[i]) begin
        cnt_d[i] = '0;
        if (pend[i]) begin
          act_d[i] = nxt_q[i];
        end
        pend_d[i] = 1'b0;
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
      tick_d[i] = en[i] && !sync && wrap[i];
      if (div_wr[i]) begin
        nxt_d[i]  = div_in;
        pend_d[i] = 1'b1;
      end
      // The level follows the count held in the coming cycle, under the divisor that governs it.
      eff_d[i]     = (act_d[i] <= ONE) ? ONE : act_d[i];
      clk_out_d[i] = en[i] && !sync && (cnt_d[i] >= (eff_d[i] >> 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      act_q   <= {NCH{DEF}};
      nxt_q   <= {NCH{DEF}};
      pend    <= '0;
      tick    <= '0;
      clk_out <= '0;
    end else begin
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      nxt_q   <= nxt_d;
      pend    <= pend_d;
      tick    <= tick_d;
      clk_out <= clk_out_d;
    end
  end

endmodule
